axi_r_arbiter: RTL and testbench

Burst-locked round-robin arbiter that merges the AXI read-data (R) channels of N_SLAVE upstream read buffers into one downstream R channel. Sits between the per-port R-channel FIFOs of the instruction/data fetch path and the shared consumer. Grants one source per burst and holds the grant until the RLAST beat completes. R beats from different sources are never interleaved.

---
 rtl/axi_r_arb_pkg.sv | 18 +
 rtl/axi_r_arbiter_rr_pick.sv | 32 +++
 rtl/axi_r_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_r_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_r_arb_pkg.sv
// Shared types and constants for the burst-locked AXI R-channel arbiter.
package axi_r_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [1:0] RRESP_EXOKAY = 2'b01;
   localparam logic [1:0] RRESP_SLVERR = 2'b10;
   localparam logic [1:0] RRESP_DECERR = 2'b11;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_r_arbiter_rr_pick.sv
// Round-robin first-one finder: first asserted req at or after ptr, wrapping mod N.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [PW-1:0] idx_o,
   output logic          found_o
);

   logic [N-1:0] rot;
   logic [PW:0]  off;
   logic [PW:0]  sum;

   always_comb begin
      // rotate so bit 0 is the requester at the pointer
      rot     = N'({req_i, req_i} >> ptr_i);
      off     = '0;
      found_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off     = (PW+1)'(i);
            found_o = 1'b1;
         end
      end
      sum = {1'b0, ptr_i} + off;
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx_o = sum[PW-1:0];
   end

endmodule

// File: rtl/axi_r_arbiter.sv
// Burst-locked round-robin merge of N_SLAVE AXI R channels into one.
// Define AXI_R_ARB_OUT_REG_EN to place a 2-entry skid register on the master channel.
import axi_r_arb_pkg::*;

module axi_r_arbiter #(
   parameter int N_SLAVE    = 4,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 6
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [N_SLAVE-1:0]             slave_valid_i,
   input  logic [N_SLAVE*DATA_WIDTH-1:0]  slave_data_i,
   input  logic [2*N_SLAVE-1:0]           slave_resp_i,
   input  logic [N_SLAVE*USER_WIDTH-1:0]  slave_user_i,
   input  logic [N_SLAVE*ID_WIDTH-1:0]    slave_id_i,
   input  logic [N_SLAVE-1:0]             slave_last_i,
   output logic [N_SLAVE-1:0]             slave_ready_o,
   output logic                           master_valid_o,
   output logic [DATA_WIDTH-1:0]          master_data_o,
   output logic [1:0]                     master_resp_o,
   output logic [USER_WIDTH-1:0]          master_user_o,
   output logic [ID_WIDTH-1:0]            master_id_o,
   output logic                           master_last_o,
   input  logic                           master_ready_i,
   output logic [N_SLAVE-1:0]             grant_o,
   output logic                           busy_o
);

   localparam int PW = ptr_width(N_SLAVE);
   localparam int BW = DATA_WIDTH + 2 + USER_WIDTH + ID_WIDTH + 1;

   state_e               state_q;
   logic [PW-1:0]        gnt_q;
   logic [PW-1:0]        ptr_q;
   logic [PW-1:0]        ptr_d;
   logic [N_SLAVE-1:0]   grant_q;
   logic                 busy_q;

   logic [PW-1:0]        pick_idx;
   logic                 pick_found;
   logic                 src_valid;
   logic                 src_last;
   logic                 acc_ready;
   logic                 hs;
   logic [BW-1:0]        src_beat;
   logic [BW-1:0]        out_beat;

   rr_pick #(.N(N_SLAVE), .PW(PW)) u_pick (
      .req_i   (slave_valid_i),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   assign src_valid = busy_q & slave_valid_i[gnt_q];
   assign src_last  = slave_last_i[gnt_q];
   assign src_beat  = {slave_data_i[gnt_q*DATA_WIDTH +: DATA_WIDTH],
                       slave_resp_i[gnt_q*2 +: 2],
                       slave_user_i[gnt_q*USER_WIDTH +: USER_WIDTH],
                       slave_id_i[gnt_q*ID_WIDTH +: ID_WIDTH],
                       src_last};
   assign hs            = src_valid & acc_ready;
   assign slave_ready_o = busy_q ? (N_SLAVE'(acc_ready) << gnt_q) : '0;
   assign ptr_d         = (gnt_q == PW'(N_SLAVE - 1)) ? '0 : gnt_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q <= BURST;
                  gnt_q   <= pick_idx;
                  grant_q <= N_SLAVE'(1) << pick_idx;
                  busy_q  <= 1'b1;
               end
            end
            BURST: begin
               // grant is frozen until the RLAST beat is accepted
               if (hs && src_last) begin
                  state_q <= IDLE;
                  ptr_q   <= ptr_d;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef AXI_R_ARB_OUT_REG_EN
   logic          out_valid_q;
   logic          skid_valid_q;
   logic [BW-1:0] out_q;
   logic [BW-1:0] skid_q;

   // upstream ready looks only at skid occupancy, never at master_ready_i
   assign acc_ready = ~skid_valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else if (!out_valid_q || master_ready_i) begin
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else begin
            out_q       <= hs ? src_beat : '0;
            out_valid_q <= hs;
         end
      end else if (hs) begin
         skid_q       <= src_beat;
         skid_valid_q <= 1'b1;
      end
   end

   assign master_valid_o = out_valid_q;
   assign out_beat       = out_q;
`else
   assign acc_ready      = master_ready_i;
   assign master_valid_o = src_valid;
   assign out_beat       = busy_q ? src_beat : '0;
`endif

   assign {master_data_o, master_resp_o, master_user_o, master_id_o, master_last_o} = out_beat;
   assign grant_o = grant_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_axi_r_arbiter.sv
// Directed bench for axi_r_arbiter: per-source burst generators plus hand-computed expectations.
module tb_axi_r_arbiter;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [3:0]    slave_valid_i = '0;
   logic [255:0]  slave_data_i = '0;
   logic [7:0]    slave_resp_i = '0;
   logic [23:0]   slave_user_i = '0;
   logic [15:0]   slave_id_i = '0;
   logic [3:0]    slave_last_i = '0;
   logic [3:0]    slave_ready_o;
   logic          master_valid_o;
   logic [63:0]   master_data_o;
   logic [1:0]    master_resp_o;
   logic [5:0]    master_user_o;
   logic [3:0]    master_id_o;
   logic          master_last_o;
   logic          master_ready_i = 1'b0;
   logic [3:0]    grant_o;
   logic          busy_o;

   axi_r_arbiter #(.N_SLAVE(4), .ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .slave_valid_i(slave_valid_i), .slave_data_i(slave_data_i),
      .slave_resp_i(slave_resp_i), .slave_user_i(slave_user_i),
      .slave_id_i(slave_id_i), .slave_last_i(slave_last_i),
      .slave_ready_o(slave_ready_o),
      .master_valid_o(master_valid_o), .master_data_o(master_data_o),
      .master_resp_o(master_resp_o), .master_user_o(master_user_o),
      .master_id_o(master_id_o), .master_last_o(master_last_o),
      .master_ready_i(master_ready_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   int         len [4];
   int         bn  [4];
   logic [1:0] rresp [4];
   logic [3:0] rid [4];
   bit         refill = 1'b0;

   logic        obs_valid, obs_last, obs_busy;
   logic [63:0] obs_data;
   logic [1:0]  obs_resp;
   logic [3:0]  obs_id, obs_grant, obs_sready;
   logic [5:0]  obs_user;
   logic [1:0]  obs_ptr;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_src();
      for (int k = 0; k < 4; k++) begin
         slave_valid_i[k]         = (len[k] > 0);
         slave_last_i[k]          = (len[k] == 1);
         slave_data_i[k*64 +: 64] = {48'h0, 8'(k), 8'(bn[k])};
         slave_resp_i[k*2 +: 2]   = rresp[k];
         slave_user_i[k*6 +: 6]   = 6'(k + 1);
         slave_id_i[k*4 +: 4]     = rid[k];
      end
   endtask

   // observe at negedge, advance source models just after the rising edge
   task automatic cycle();
      logic [3:0] hsv;
      @(negedge clk_i);
      obs_valid  = master_valid_o;
      obs_data   = master_data_o;
      obs_resp   = master_resp_o;
      obs_user   = master_user_o;
      obs_id     = master_id_o;
      obs_last   = master_last_o;
      obs_grant  = grant_o;
      obs_busy   = busy_o;
      obs_sready = slave_ready_o;
      obs_ptr    = dut.ptr_q;
      hsv        = slave_valid_i & slave_ready_o;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (hsv[k]) begin
            len[k]--;
            bn[k]++;
            if (len[k] == 0 && refill) len[k] = 2;
         end
      end
      drive_src();
   endtask

   task automatic do_reset();
      rst_i          = 1'b1;
      refill         = 1'b0;
      master_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         len[k] = 0; bn[k] = 0; rresp[k] = 2'b00; rid[k] = 4'(k);
      end
      drive_src();
      cycle();
      cycle();
      rst_i = 1'b0;
   endtask

   initial begin
      int  got;
      bit  prev_stall;
      logic [63:0] prev_data;
      logic [3:0]  sr1, sr0;
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      do_reset();
      cycle();
      check_eq("rst_valid", 64'(obs_valid), 64'h0);
      check_eq("rst_busy",  64'(obs_busy),  64'h0);
      check_eq("rst_grant", 64'(obs_grant), 64'h0);
      check_eq("rst_ready", 64'(obs_sready), 64'h0);
      check_eq("rst_data",  obs_data,        64'h0);
      check_eq("rst_ptr",   64'(obs_ptr),    64'h0);

      // single source 2, 4 beats, ID 3
      master_ready_i = 1'b1;
      len[2] = 4; rid[2] = 4'h3;
      drive_src();
      cycle();
      check_eq("s1_idle_valid", 64'(obs_valid), 64'h0);
      check_eq("s1_idle_data",  obs_data,       64'h0);
`ifdef AXI_R_ARB_OUT_REG_EN
      #2;
      sr1 = slave_ready_o;
      master_ready_i = 1'b0;
      #1;
      sr0 = slave_ready_o;
      master_ready_i = 1'b1;
      check_eq("s1r_ready_indep", 64'(sr0), 64'(sr1));
      cycle();
      check_eq("s1r_extra_lat", 64'(obs_valid), 64'h0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("s1r_valid", 64'(obs_valid), 64'h1);
         check_eq("s1r_data",  obs_data,       64'h0200 + 64'(i));
         check_eq("s1r_last",  64'(obs_last),  64'(i == 3));
      end
      cycle();
      check_eq("s1r_drain", 64'(obs_valid), 64'h0);
      check_eq("s1r_ptr",   64'(obs_ptr),   64'h3);
`else
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("s1_valid", 64'(obs_valid), 64'h1);
         check_eq("s1_data",  obs_data,       64'h0200 + 64'(i));
         check_eq("s1_id",    64'(obs_id),    64'h3);
         check_eq("s1_user",  64'(obs_user),  64'h3);
         check_eq("s1_last",  64'(obs_last),  64'(i == 3));
         check_eq("s1_grant", 64'(obs_grant), 64'h4);
      end
      cycle();
      check_eq("s1_end_busy",  64'(obs_busy),  64'h0);
      check_eq("s1_end_grant", 64'(obs_grant), 64'h0);
      check_eq("s1_end_valid", 64'(obs_valid), 64'h0);
      check_eq("s1_end_ptr",   64'(obs_ptr),   64'h3);

      // all four sources, continuous 2-beat bursts
      do_reset();
      master_ready_i = 1'b1;
      refill = 1'b1;
      for (int k = 0; k < 4; k++) len[k] = 2;
      drive_src();
      for (int c = 0; c < 15; c++) begin
         cycle();
         if (c % 3 == 0) begin
            check_eq("rr_bubble_grant", 64'(obs_grant), 64'h0);
            check_eq("rr_bubble_valid", 64'(obs_valid), 64'h0);
         end else begin
            check_eq("rr_grant", 64'(obs_grant), 64'(4'b1 << ((c / 3) % 4)));
            check_eq("rr_src",   64'(obs_data[15:8]), 64'((c / 3) % 4));
            check_eq("rr_last",  64'(obs_last), 64'(c % 3 == 2));
         end
      end

      // no interleave: source 0 requests while source 1 is mid-burst
      do_reset();
      master_ready_i = 1'b1;
      len[1] = 4;
      drive_src();
      cycle();
      cycle();
      check_eq("ni_grant1", 64'(obs_grant), 64'h2);
      len[0] = 2;
      drive_src();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("ni_rdy0_low", 64'(obs_sready[0]), 64'h0);
         check_eq("ni_src1",     64'(obs_data[15:8]), 64'h1);
      end
      cycle();
      check_eq("ni_bubble_ptr", 64'(obs_ptr), 64'h2);
      check_eq("ni_bubble_valid", 64'(obs_valid), 64'h0);
      cycle();
      check_eq("ni_grant0", 64'(obs_grant), 64'h1);
      check_eq("ni_rdy0",   64'(obs_sready), 64'h1);
      cycle();
      check_eq("ni_last0",  64'(obs_last), 64'h1);
      cycle();
      check_eq("ni_ptr_after", 64'(obs_ptr), 64'h1);

      // backpressure with SLVERR beats, ready pattern 1,0,0,1
      len[0] = 8; bn[0] = 0; rresp[0] = 2'b10;
      drive_src();
      got = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         master_ready_i = pat[c % 4];
         cycle();
         if (obs_valid) begin
            check_eq("bp_resp", 64'(obs_resp), 64'h2);
            check_eq("bp_beat", 64'(obs_data[7:0]), 64'(got));
            if (prev_stall) check_eq("bp_hold", obs_data, prev_data);
            if (master_ready_i) begin
               check_eq("bp_last", 64'(obs_last), 64'(got == 7));
               got++;
            end
         end
         prev_stall = obs_valid && !master_ready_i;
         prev_data  = obs_data;
      end
      check_eq("bp_count", 64'(got), 64'h8);
      master_ready_i = 1'b1;
      cycle();
      check_eq("bp_no_dup", 64'(obs_valid), 64'h0);

      // reset mid-burst at beat 3 of 8 (source 3)
      len[3] = 8; bn[3] = 0;
      drive_src();
      cycle();
      cycle();
      cycle();
      check_eq("mr_grant", 64'(obs_grant), 64'h8);
      rst_i = 1'b1;
      cycle();
      check_eq("mr_beat3", 64'(obs_data[7:0]), 64'h2);
      rst_i = 1'b0;
      cycle();
      check_eq("mr_busy",  64'(obs_busy),  64'h0);
      check_eq("mr_grant0", 64'(obs_grant), 64'h0);
      check_eq("mr_valid", 64'(obs_valid), 64'h0);
      check_eq("mr_ptr",   64'(obs_ptr),   64'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
